// File: rtl/maxpool_pkg.sv
// Shared types and helpers for maxpool_stream; MAXPOOL_SIGNED_EN switches the lane compare to signed.
package maxpool_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, LAST} state_t;

  localparam int LANE_MAX_W = 32;

`ifdef MAXPOOL_SIGNED_EN
  localparam bit SIGNED_CMP = 1'b1;
`else
  localparam bit SIGNED_CMP = 1'b0;
`endif

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Flipping the sign bit of both operands turns an unsigned compare into a signed one.
  function automatic logic [LANE_MAX_W-1:0] lane_max(input logic [LANE_MAX_W-1:0] a,
                                                      input logic [LANE_MAX_W-1:0] b,
                                                      input int w);
    logic [LANE_MAX_W-1:0] flip;
    flip = SIGNED_CMP ? (LANE_MAX_W'(1) << (w - 1)) : '0;
    return ((a ^ flip) > (b ^ flip)) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// K-1 cascaded row delay lines addressed by column; each tap returns the pixel one row further up.
module maxpool_linebuf
  import maxpool_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int ROWS  = 2,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [W-1:0]      din,
  output logic [ROWS*W-1:0] taps
);

  logic [W-1:0] mem [ROWS][DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0][addr] <= din;
      for (int r = 1; r < ROWS; r++) mem[r][addr] <= mem[r-1][addr];
    end
  end

  always_comb begin
    taps = '0;
    for (int r = 0; r < ROWS; r++) taps[r*W +: W] = mem[r][addr];
  end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming KxK max-pool with stride over raster input, CH lanes; MAXPOOL_SIGNED_EN selects signed compare.
// out_valid one cycle after the window-completing pixel; in_ready drops while output stalls or last beat pends.
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last
);

  localparam int LW       = CH * DATA_W;
  localparam int OUT_W    = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H    = out_dim(IMG_H, K, STRIDE);
  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LAST_COL = K - 1 + (OUT_W - 1) * STRIDE;
  localparam int LAST_ROW = K - 1 + (OUT_H - 1) * STRIDE;
  localparam int NT       = (K > 1) ? K - 1 : 1;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            acc, emit, frame_end;
  logic [NT*LW-1:0] taps;
  logic [LW-1:0]   new_col [K];
  logic [LW-1:0]   win     [K][K];
  logic [LW-1:0]   win_max;

  assign in_ready  = !rst && (state != LAST) && (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign frame_end = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

  generate
    if (K > 1) begin : g_lb
      maxpool_linebuf #(.W(LW), .DEPTH(IMG_W), .ROWS(K - 1), .AW(CW)) u_linebuf (
        .clk  (clk),
        .en   (acc),
        .addr (col),
        .din  (in_data),
        .taps (taps)
      );
    end else begin : g_nolb
      assign taps = '0;
    end
  endgenerate

  // new_col[K-1] is the current row; lower indices reach further up the image.
  always_comb begin
    for (int r = 0; r < K; r++) new_col[r] = '0;
    new_col[K-1] = in_data;
    for (int t = 0; t < K - 1; t++) new_col[K-2-t] = taps[t*LW +: LW];
  end

  always_comb begin
    emit = (int'(col) >= K - 1) && (int'(row) >= K - 1) &&
           (((int'(col) - (K - 1)) % STRIDE) == 0) &&
           (((int'(row) - (K - 1)) % STRIDE) == 0);
  end

  // Max over the window as it will look after this pixel shifts in.
  always_comb begin
    logic [LANE_MAX_W-1:0] m;
    logic [LANE_MAX_W-1:0] v;
    win_max = '0;
    for (int l = 0; l < CH; l++) begin
      m = LANE_MAX_W'(new_col[0][l*DATA_W +: DATA_W]);
      for (int r = 0; r < K; r++) begin
        v = LANE_MAX_W'(new_col[r][l*DATA_W +: DATA_W]);
        m = lane_max(m, v, DATA_W);
        for (int c = 1; c < K; c++) begin
          v = LANE_MAX_W'(win[r][c][l*DATA_W +: DATA_W]);
          m = lane_max(m, v, DATA_W);
        end
      end
      win_max[l*DATA_W +: DATA_W] = m[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACTIVE: if (acc) state <= frame_end ? LAST : ACTIVE;
        // The last beat may already have left if trailing pixels were discarded.
        LAST:         if (!out_valid || out_ready) state <= IDLE;
        default:      state <= IDLE;
      endcase

      if (acc) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (acc && emit) begin
        out_valid <= 1'b1;
        out_data  <= win_max;
        out_last  <= (col == CW'(LAST_COL)) && (row == RW'(LAST_ROW));
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench: dut0 is 8x8 K=3 S=1 CH=2, dut1 is 8x8 K=2 S=2 CH=1; expectations come from a window-max model.
module tb_maxpool_stream;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_last0;
  logic [15:0] in_data0, out_data0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic [7:0]  in_data1, out_data1;

  maxpool_stream #(.DATA_W(8), .CH(2), .IMG_W(8), .IMG_H(8), .K(3), .STRIDE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_last(out_last0));

  maxpool_stream #(.DATA_W(8), .CH(1), .IMG_W(8), .IMG_H(8), .K(2), .STRIDE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1));

  int checks = 0;
  int fails  = 0;
  int out_cnt0, last_cnt0, out_cnt1, last_cnt1, stall0;
  bit ign0     = 1'b0;
  bit rdy_rand = 1'b0;

  logic [15:0] img0 [64];
  logic [7:0]  img1 [64];
  logic [16:0] q0 [$];
  logic [8:0]  q1 [$];

  function automatic bit gt8(input logic [7:0] a, input logic [7:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [7:0] wmax0(input int oi, input int oj, input int lane);
    logic [7:0] m, v;
    m = img0[oi*8 + oj][lane*8 +: 8];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        v = img0[(oi + r)*8 + oj + c][lane*8 +: 8];
        if (gt8(v, m)) m = v;
      end
    return m;
  endfunction

  function automatic logic [7:0] wmax1(input int oi, input int oj);
    logic [7:0] m, v;
    m = img1[(oi*2)*8 + oj*2];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        v = img1[(oi*2 + r)*8 + oj*2 + c];
        if (gt8(v, m)) m = v;
      end
    return m;
  endfunction

  task automatic push_exp0();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        q0.push_back({(i == 5 && j == 5), wmax0(i, j, 1), wmax0(i, j, 0)});
  endtask

  task automatic push_exp1();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        q1.push_back({(i == 3 && j == 3), wmax1(i, j)});
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      out_ready0 = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready1 = 1'b1;
    end
  endtask

  task automatic sb_monitor();
    logic [16:0] e0, h0;
    logic [8:0]  e1;
    bit st0;
    st0 = 1'b0;
    h0  = '0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid0 && !ign0) begin
        if (st0) begin
          checks++;
          if ({out_last0, out_data0} !== h0) begin
            fails++;
            $display("FAIL stall_hold0 got=%h want=%h", {out_last0, out_data0}, h0);
          end
        end
        if (out_ready0) begin
          checks++;
          if (q0.size() == 0) begin
            fails++;
            $display("FAIL extra_out0 got=%h want=no output", {out_last0, out_data0});
          end else begin
            e0 = q0.pop_front();
            if ({out_last0, out_data0} !== e0) begin
              fails++;
              $display("FAIL sb_out0 got=%h want=%h", {out_last0, out_data0}, e0);
            end
          end
          out_cnt0++;
          if (out_last0) last_cnt0++;
          st0 = 1'b0;
        end else begin
          st0 = 1'b1;
          h0  = {out_last0, out_data0};
        end
      end else begin
        st0 = 1'b0;
      end
      if (!rst && out_valid1 && out_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL extra_out1 got=%h want=no output", {out_last1, out_data1});
        end else begin
          e1 = q1.pop_front();
          if ({out_last1, out_data1} !== e1) begin
            fails++;
            $display("FAIL sb_out1 got=%h want=%h", {out_last1, out_data1}, e1);
          end
        end
        out_cnt1++;
        if (out_last1) last_cnt1++;
      end
    end
  endtask

  task automatic send(input int sel, input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      int t;
      t = 0;
      if (sel == 0) begin in_valid0 = 1'b1; in_data0 = img0[p]; end
      else begin in_valid1 = 1'b1; in_data1 = img1[p]; end
      @(negedge clk);
      while (((sel == 0) ? !in_ready0 : !in_ready1) && t < 500) begin
        if (sel == 0) stall0++;
        t++;
        @(negedge clk);
      end
      if (t >= 500) begin
        checks++;
        fails++;
        $display("FAIL send_timeout dut=%0d pixel=%0d in_ready got=0 want=1", sel, p);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int sel);
    int t;
    t = 0;
    while (((sel == 0) ? (q0.size() != 0 || out_valid0) : (q1.size() != 0 || out_valid1)) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 1000) begin
      fails++;
      $display("FAIL drain_timeout dut=%0d pending got=%0d want=0", sel, (sel == 0) ? q0.size() : q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    out_cnt0 = 0; last_cnt0 = 0; out_cnt1 = 0; last_cnt1 = 0; stall0 = 0;
  endtask

  task automatic check_counts0(input int want_out, input int want_last);
    checks++;
    if (out_cnt0 !== want_out) begin
      fails++;
      $display("FAIL out_count0 got=%0d want=%0d", out_cnt0, want_out);
    end
    checks++;
    if (last_cnt0 !== want_last) begin
      fails++;
      $display("FAIL last_count0 got=%0d want=%0d", last_cnt0, want_last);
    end
  endtask

  task automatic load_ramp0();
    for (int p = 0; p < 64; p++) img0[p] = {8'(63 - p), 8'(p)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; in_valid1 = 1'b0; in_data1 = '0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid0, out_last0, in_ready0} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl0 got=%b want=000", {out_valid0, out_last0, in_ready0});
    end
    checks++;
    if (out_data0 !== 16'h0) begin
      fails++;
      $display("FAIL reset_data0 got=%h want=0000", out_data0);
    end
    checks++;
    if ({out_valid1, out_last1, in_ready1, out_data1} !== 11'h0) begin
      fails++;
      $display("FAIL reset_dut1 got=%h want=000", {out_valid1, out_last1, in_ready1, out_data1});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    load_ramp0();
    clear_counts();
    push_exp0();
    send(0, 0, 17);
    checks++;
    if (out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL early_valid got=%b want=0", out_valid0);
    end
    send(0, 18, 18);
    checks++;
    if (out_valid0 !== 1'b1 || out_data0[7:0] !== 8'd18) begin
      fails++;
      $display("FAIL first_out valid/data got=%b/%0d want=1/18", out_valid0, out_data0[7:0]);
    end
    send(0, 19, 63);
    in_valid0 = 1'b0;
    drain(0);
    check_counts0(36, 1);
    checks++;
    if (stall0 !== 0) begin
      fails++;
      $display("FAIL ramp_throughput stalls got=%0d want=0", stall0);
    end
  endtask

  task automatic test_stride2();
    for (int p = 0; p < 64; p++) img1[p] = 8'(p);
    clear_counts();
    push_exp1();
    send(1, 0, 63);
    in_valid1 = 1'b0;
    drain(1);
    checks++;
    if (out_cnt1 !== 16 || last_cnt1 !== 1) begin
      fails++;
      $display("FAIL stride2_counts got=%0d/%0d want=16/1", out_cnt1, last_cnt1);
    end
  endtask

  task automatic test_backpressure();
    load_ramp0();
    clear_counts();
    push_exp0();
    rdy_rand = 1'b1;
    send(0, 0, 63);
    in_valid0 = 1'b0;
    drain(0);
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    check_counts0(36, 1);
  endtask

  task automatic test_signed_compare();
    for (int p = 0; p < 64; p++) img0[p] = {((p == 27) ? 8'h80 : 8'hFF), 8'h01};
    clear_counts();
    push_exp0();
    send(0, 0, 63);
    in_valid0 = 1'b0;
    drain(0);
    check_counts0(36, 1);
    // Every 3-wide window mixes 0x80 and 0x7F in lane 0, so the compare sign decides the result.
    for (int p = 0; p < 64; p++) img0[p] = {8'(p * 37), (((p % 3) == 0) ? 8'h80 : 8'h7F)};
    clear_counts();
    push_exp0();
    send(0, 0, 63);
    in_valid0 = 1'b0;
    drain(0);
    check_counts0(36, 1);
  endtask

  task automatic test_reset_mid();
    load_ramp0();
    ign0 = 1'b1;
    send(0, 0, 19);
    rst = 1'b1;
    in_valid0 = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async got=%b%b want=00", out_valid0, in_ready0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_last0 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_hold got=%b%b want=00", out_valid0, out_last0);
    end
    rst = 1'b0;
    ign0 = 1'b0;
    @(posedge clk);
    #1;
    clear_counts();
    push_exp0();
    send(0, 0, 63);
    in_valid0 = 1'b0;
    drain(0);
    check_counts0(36, 1);
  endtask

  task automatic test_back_to_back();
    load_ramp0();
    clear_counts();
    push_exp0();
    push_exp0();
    send(0, 0, 63);
    send(0, 0, 63);
    in_valid0 = 1'b0;
    drain(0);
    check_counts0(72, 2);
    checks++;
    if (stall0 !== 1) begin
      fails++;
      $display("FAIL frame_gap in_ready low cycles got=%0d want=1", stall0);
    end
  endtask

  initial begin
    fork
      sb_monitor();
      ready_driver();
      begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
      end
    join_none
    test_reset();
    test_ramp();
    test_stride2();
    test_backpressure();
    test_signed_compare();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming, parametrised max-pooling stage for the CNN datapath. It accepts a feature map in raster order, one pixel per cycle over a valid/ready handshake, and holds K-1 rows in line buffers. It emits the maximum of every KxK window at a configurable stride, with one output pixel per window on a second valid/ready handshake. It sits between a convolution stage and the next layer, and processes CH channels in lock-step lanes.

## Interface
- DATA_W, 8, bits per channel sample
- CH, 1, channels packed per pixel, processed independently
- IMG_W, 8, input columns
- IMG_H, 8, input rows
- K, 3, window size (KxK); 1 <= K <= min(IMG_W, IMG_H)
- STRIDE, 1, window step in both axes; >= 1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  CH*DATA_W  pixel; channel c at bits [c*DATA_W +: DATA_W]
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  CH*DATA_W  pooled pixel, same packing
- out_last  out  1  qualifies the final pooled pixel of a frame

## Operation
- Output size: OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1, using integer division. Trailing columns and rows that no window covers are consumed and discarded.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance on each input handshake (in_valid & in_ready). col wraps to 0 and increments row.
- Line buffer: K-1 rows of IMG_W x CH*DATA_W. The window register is KxK and shifts left on each accepted pixel, with its new column taken from the line buffer taps plus in_data.
- Emit condition on the accepting cycle: col >= K-1, row >= K-1, (col-K+1) % STRIDE == 0, and (row-K+1) % STRIDE == 0.
- Per lane, the max is taken over the K*K values, using an unsigned compare unless the signed-compare macro is defined (see Configuration).
- FSM:
  - IDLE: no pixel of the current frame accepted yet. The first handshake moves to ACTIVE.
  - ACTIVE: on the handshake of pixel (IMG_H-1, IMG_W-1), move to LAST.
  - LAST: in_ready = 0 until the out_last beat handshakes, then return to IDLE. Counters are already at 0.
- Backpressure: in_ready = (state != LAST) & (!out_valid | out_ready). The output register never drops or duplicates a result.
- out_last = 1 exactly on the emit of window (OUT_H-1, OUT_W-1).
- Reset values: out_valid 0, out_data 0, out_last 0, in_ready 0 while rst is high. The FSM returns to IDLE and the counters go to 0. Line buffer contents are don't-care.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).

## Timing
- Latency: out_valid rises the cycle after the handshake of the pixel that completes a window.
- Throughput: one input pixel per cycle when out_ready is held high.
- The last-pixel handshake and the LAST hold cost one extra cycle before the next frame's first pixel is accepted.
- While out_valid=1 and out_ready=0: out_data and out_last hold stable, and in_ready=0.
- Simultaneous out handshake and completing input on the same cycle: the register reloads with no bubble.

## Configuration
- MAXPOOL_SIGNED_EN:
  - Defined: samples are two's-complement, and the compare is signed. 8'hFF (-1) < 8'h01.
  - Undefined: samples are unsigned. 8'hFF > 8'h01.

## Structure
- Shared package maxpool_pkg holds:
  - the function computing OUT_W/OUT_H from (IMG, K, STRIDE)
  - the FSM state typedef (IDLE, ACTIVE, LAST)
  - the per-lane max function, whose compare is selected by MAXPOOL_SIGNED_EN
- One sub-module, maxpool_linebuf: K-1 row delay lines of depth IMG_W with enable (the input handshake) and K-1 tap outputs.

## Test plan
- Defaults, ramp input 0..63, out_ready=1 -> 36 outputs; out[i][j] = 8*(i+2)+(j+2); first 18, last 63 with out_last=1; first out_valid 1 cycle after pixel 18 accepted.
- K=2, STRIDE=2, 8x8, ramp -> 16 outputs 9, 11, 13, 15, 25, …, 63; out_last on the 16th only.
- Defaults, out_ready toggled by pseudo-random 50% pattern -> output sequence identical to the first test; out_data stable while stalled; no pixel lost.
- MAXPOOL_SIGNED_EN, CH=2, all pixels lane0=8'h01 and lane1=8'hFF except one 8'h80 in lane1 -> lane0 all 1 and lane1 all 8'hFF (-1). Without the macro: lane1 windows containing 8'h80 still give 8'hFF.
- Reset asserted after 20 input pixels, then a full ramp frame -> outputs exactly match the first test; out_valid=0 during reset.
- Two back-to-back ramp frames with in_valid held high -> 72 outputs, two out_last pulses, one in_ready=0 cycle between frames.
